dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the five-stage RV32IM pipeline: the far end of the core's MA-stage data-memory port. It decodes read/write requests (byte/half/word, signed/unsigned), stalls the core via `BUSYWAIT` for a programmable access latency, then performs the store or returns the extended load data. It sits beside the core in the top-level SoC and replaces the ideal single-cycle memory model used in early bring-up.

## Interface
- `DEPTH`, 1024: storage size in 32-bit words; power of two.
- `LATENCY`, 4: cycles `BUSYWAIT` stays high per access; minimum 1.
- `CLK` input 1: the single clock.
- `RST` input 1: reset, asynchronous, active-low.
- `DMEM_ADDR` input 32: byte address from the core's MA stage.
- `DMEM_DATA_WRITE` input 32: store data; the low byte/half is used for narrow stores.
- `DMEM_READ` input 4: [3] is read enable; [2:0] is funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
- `DMEM_WRITE` input 3: [2] is write enable; [1:0] is size (00 byte, 01 half, 10 word).
- `DMEM_DATA_READ` output 32: extended load data, valid in DONE.
- `BUSYWAIT` output 1: stalls all core pipeline registers and the PC while high.
- `DMEM_MISALIGNED` output 1: one-cycle pulse in DONE when the serviced access was misaligned.

## Operation
- States:
  - IDLE: no access in progress.
  - ACCESS: countdown.
  - DONE: one cycle; request retired by the core at the closing edge.
- IDLE, request present (`DMEM_READ[3]` or `DMEM_WRITE[2]`): `BUSYWAIT` asserts combinationally in the same cycle. Address, data and op are captured at the edge.
  - `LATENCY`==1: go to DONE.
  - Otherwise: go to ACCESS with the counter set to `LATENCY`-2.
- ACCESS: `BUSYWAIT`=1. The counter decrements each cycle. At 0 the access is performed at the edge and the state goes to DONE.
- DONE: `BUSYWAIT`=0 and the request inputs are ignored, because it is the same request being retired. Next state is IDLE unconditionally.
- Read and write both enabled: write wins, and the read is not performed.
- Word index is `addr[log2(DEPTH)+1:2]`. Higher bits are ignored, so addresses wrap modulo `DEPTH`*4.
- Byte lane comes from `addr[1:0]`:
  - Half access uses `addr[1]`; `addr[0]`=1 is misaligned.
  - Word access with `addr[1:0]`≠0 is misaligned.
  - A misaligned access is still performed with the low address bits forced to 0, and `DMEM_MISALIGNED` pulses.
- Stores write only the addressed byte lanes; the other lanes are unchanged.
- Loads: LB/LH sign-extend from bit 7/15. LBU/LHU zero-extend. LW is passed through.
- An invalid read funct3 (011, 11x) returns 0 and still completes with full latency.
- Writes leave `DMEM_DATA_READ` unchanged.

## Timing
- Reset: state IDLE, counter 0, `BUSYWAIT`=0 (when no request is present), `DMEM_DATA_READ`=0, `DMEM_MISALIGNED`=0. Storage contents are not reset.
- Request first seen in cycle 0:
  - `BUSYWAIT` is high in cycles 0 to `LATENCY`-1.
  - Cycle `LATENCY` is DONE: load data valid, `BUSYWAIT` low.
  - The core samples the data at the end of cycle `LATENCY`.
- Back-to-back accesses: the next request is seen in cycle `LATENCY`+1 (IDLE). Sustained throughput is one access per `LATENCY`+1 cycles.
- Store data is visible to a load issued in any later access.
- Reset asserted mid-access: immediate return to IDLE and `BUSYWAIT`=0. An in-flight store is not written.
- Request inputs may change during ACCESS; only the captured values are used.

## Structure
- Shared package `mem_ops_pkg` holds:
  - read funct3 codes;
  - write size codes;
  - the enable bit positions of `DMEM_READ`/`DMEM_WRITE`;
  - state encodings (IDLE=0, ACCESS=1, DONE=2).
  - The core's control unit uses the same package for encoding.
- One sub-module, `dmem_array`: a synchronous `DEPTH`x32 array with a 4-bit byte-write-enable and registered read. Lane selection and extension stay in `dmem_responder`.

## Test plan
- Reset, then SW 0xDEADBEEF to addr 0x10 and LW 0x10 with `LATENCY`=4 -> `BUSYWAIT` is high for exactly 4 cycles per access, and `DMEM_DATA_READ`=0xDEADBEEF in DONE.
- After that word: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
- SB 0x55 to 0x11 over 0xDEADBEEF, then LW 0x10 -> 0xDEAD55EF; SH 0x1234 to 0x12, then LW -> 0x123455EF.
- LW at 0x12 -> `DMEM_MISALIGNED` pulses once in DONE and the data is the word at 0x10. With `DEPTH`=1024, LW at 0x1010 returns the word at 0x10 (wrap).
- Back-to-back SW then LW with `LATENCY`=1 -> `BUSYWAIT` is high 1 cycle each, with one DONE cycle between them, and the load returns the stored value. Read and write asserted together -> write performed, read data unchanged.
- Assert `RST` in cycle 2 of a `LATENCY`=4 store -> `BUSYWAIT` drops immediately and a later load returns the old contents.

Source files
------------

// File: rtl/mem_ops_pkg.sv
// Shared encodings for the data-memory port: read funct3 codes, store size
// codes, enable bit positions, responder FSM states and lane helpers.
package mem_ops_pkg;

  // DMEM_READ = {read_en, funct3}
  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } rd_funct3_e;

  // DMEM_WRITE = {write_en, size}
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } wr_size_e;

  localparam int RD_EN_BIT = 3;
  localparam int WR_EN_BIT = 2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // Access width of a request: {is_half, is_word}
  function automatic logic [1:0] access_kind(input logic is_wr, input logic [1:0] size,
                                             input logic [2:0] f3);
    logic half;
    logic word;
    half = is_wr ? (size == SZ_HALF) : (f3 == F3_LH || f3 == F3_LHU);
    word = is_wr ? (size == SZ_WORD) : (f3 == F3_LW);
    access_kind = {half, word};
  endfunction

  function automatic logic is_misaligned(input logic [1:0] kind, input logic [1:0] a);
    is_misaligned = (kind[1] & a[0]) | (kind[0] & (a != 2'b00));
  endfunction

  // Misaligned accesses are serviced with the offending low bits cleared
  function automatic logic [1:0] align_lo(input logic [1:0] kind, input logic [1:0] a);
    if (kind[0])      align_lo = 2'b00;
    else if (kind[1]) align_lo = {a[1], 1'b0};
    else              align_lo = a;
  endfunction

  function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: store_mask = 4'b0001 << a;
      SZ_HALF: store_mask = a[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: store_mask = 4'b1111;
      default: store_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] d);
    case (size)
      SZ_BYTE: store_data = {4{d[7:0]}};
      SZ_HALF: store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f3,
                                              input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{a, 3'b000} +: 8];
    h = a[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_LB:   load_extend = {{24{b[7]}}, b};
      F3_LH:   load_extend = {{16{h[15]}}, h};
      F3_LW:   load_extend = word;
      F3_LBU:  load_extend = {24'h0, b};
      F3_LHU:  load_extend = {16'h0, h};
      default: load_extend = 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core-to-memory data port.
// Handshake: the core holds a request (DMEM_READ[3] or DMEM_WRITE[2]) with
// stable fields while BUSYWAIT is high; the first cycle with the request
// present and BUSYWAIT low is DONE, and the request retires at its closing
// edge. DMEM_DATA_READ and DMEM_MISALIGNED are meaningful only in that cycle.
interface dmem_responder_if;
  logic [31:0] DMEM_ADDR;
  logic [31:0] DMEM_DATA_WRITE;
  logic [3:0]  DMEM_READ;
  logic [2:0]  DMEM_WRITE;
  logic [31:0] DMEM_DATA_READ;
  logic        BUSYWAIT;
  logic        DMEM_MISALIGNED;

  modport master (
    output DMEM_ADDR, DMEM_DATA_WRITE, DMEM_READ, DMEM_WRITE,
    input  DMEM_DATA_READ, BUSYWAIT, DMEM_MISALIGNED
  );

  modport slave (
    input  DMEM_ADDR, DMEM_DATA_WRITE, DMEM_READ, DMEM_WRITE,
    output DMEM_DATA_READ, BUSYWAIT, DMEM_MISALIGNED
  );
endinterface

// File: rtl/dmem_array.sv
// DEPTH x 32 synchronous storage with byte write enables and registered read.
// Contents are never reset.
module dmem_array #(
  parameter int DEPTH = 1024
) (
  input  logic                     i_clk,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [3:0]               i_we,
  input  logic [31:0]              i_wdata,
  input  logic                     i_re,
  output logic [31:0]              o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  // Byte-lane writes and read register (read data held between reads)
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_we[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
    end
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: stalls the core for LATENCY cycles per access, then
// performs the store or presents the extended load data for one DONE cycle.
module dmem_responder
  import mem_ops_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 4
) (
  input  logic             CLK,
  input  logic             RST,
  dmem_responder_if.slave  bus,
  output logic [1:0]       o_dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [AW+1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_rd;
  logic [2:0]    r_wr;
  logic          r_rd_done;
  logic          r_misaligned;
  logic [31:0]   r_data_read;

  logic          w_idle, w_req, w_start, w_fire;
  logic [AW+1:0] w_addr;
  logic [31:0]   w_wdata;
  logic [3:0]    w_rd;
  logic [2:0]    w_wr;
  logic          w_is_wr, w_is_rd;
  logic [1:0]    w_kind, w_lo;
  logic [3:0]    w_we;
  logic          w_re;
  logic [31:0]   w_rdata, w_ext;
  logic          w_unused_addr;

  assign w_idle  = (r_state == ST_IDLE);
  assign w_req   = bus.DMEM_READ[RD_EN_BIT] | bus.DMEM_WRITE[WR_EN_BIT];
  assign w_start = w_idle & w_req;
  // With LATENCY 1 the array is hit at the edge leaving IDLE, so it must see
  // the live request; otherwise it sees the captured one.
  assign w_fire  = (LATENCY == 1) ? w_start : (r_state == ST_ACCESS && r_cnt == '0);

  assign w_addr  = w_idle ? bus.DMEM_ADDR[AW+1:0] : r_addr;
  assign w_wdata = w_idle ? bus.DMEM_DATA_WRITE   : r_wdata;
  assign w_rd    = w_idle ? bus.DMEM_READ         : r_rd;
  assign w_wr    = w_idle ? bus.DMEM_WRITE        : r_wr;
  assign w_unused_addr = ^bus.DMEM_ADDR[31:AW+2];

  // Write wins over a simultaneous read
  assign w_is_wr = w_wr[WR_EN_BIT];
  assign w_is_rd = w_rd[RD_EN_BIT] & ~w_is_wr;
  assign w_kind  = access_kind(w_is_wr, w_wr[1:0], w_rd[2:0]);
  assign w_lo    = align_lo(w_kind, w_addr[1:0]);
  assign w_we    = (w_fire & w_is_wr) ? store_mask(w_wr[1:0], w_lo) : 4'b0000;
  assign w_re    = w_fire & w_is_rd;

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .i_clk   (CLK),
    .i_addr  (w_addr[AW+1:2]),
    .i_we    (w_we),
    .i_wdata (store_data(w_wr[1:0], w_wdata)),
    .i_re    (w_re),
    .o_rdata (w_rdata)
  );

  // In DONE the mux selects the captured op, so lane/extension follow it
  assign w_ext = load_extend(w_rdata, w_rd[2:0], w_lo);

  // FSM, latency counter and request capture
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rd    <= '0;
      r_wr    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_addr  <= bus.DMEM_ADDR[AW+1:0];
            r_wdata <= bus.DMEM_DATA_WRITE;
            r_rd    <= bus.DMEM_READ;
            r_wr    <= bus.DMEM_WRITE;
            if (LATENCY == 1) begin
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_ACCESS;
              r_cnt   <= CW'((LATENCY > 1) ? LATENCY - 2 : 0);
            end
          end
        end
        ST_ACCESS: begin
          if (r_cnt == '0) r_state <= ST_DONE;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // DONE-cycle flags and held load data
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rd_done    <= 1'b0;
      r_misaligned <= 1'b0;
      r_data_read  <= '0;
    end else begin
      r_rd_done    <= w_re;
      r_misaligned <= w_fire & is_misaligned(w_kind, w_addr[1:0]);
      if (r_state == ST_DONE && r_rd_done) r_data_read <= w_ext;
    end
  end

  assign bus.BUSYWAIT        = (r_state == ST_ACCESS) | w_start;
  assign bus.DMEM_DATA_READ  = (r_state == ST_DONE && r_rd_done) ? w_ext : r_data_read;
  assign bus.DMEM_MISALIGNED = r_misaligned;
  assign o_dbg_state         = r_state;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one LATENCY=4 and one LATENCY=1 instance,
// directed load/store cases, random back-to-back words and a mid-access reset.
module tb_dmem_responder;
  import mem_ops_pkg::*;

  localparam logic [3:0] RD_NONE = 4'b0000, RD_LB = 4'b1000, RD_LH = 4'b1001,
                         RD_LW = 4'b1010, RD_BAD = 4'b1011, RD_LBU = 4'b1100,
                         RD_LHU = 4'b1101;
  localparam logic [2:0] WR_NONE = 3'b000, WR_SB = 3'b100, WR_SH = 3'b101, WR_SW = 3'b110;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if bus4();
  dmem_responder_if bus1();
  logic [1:0] st4, st1;

  dmem_responder #(.DEPTH(1024), .LATENCY(4)) u_dut4 (
    .CLK(clk), .RST(rst_n), .bus(bus4.slave), .o_dbg_state(st4));
  dmem_responder #(.DEPTH(1024), .LATENCY(1)) u_dut1 (
    .CLK(clk), .RST(rst_n), .bus(bus1.slave), .o_dbg_state(st1));

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  logic [0:0]  exp_mis_q[$];
  logic [31:0] exp_busy_q[$];
  logic [31:0] rnd_data [8];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input int sel, input logic [3:0] rd, input logic [2:0] wr,
                       input logic [31:0] a, input logic [31:0] wd);
    if (sel == 1) begin
      bus1.DMEM_READ = rd; bus1.DMEM_WRITE = wr;
      bus1.DMEM_ADDR = a;  bus1.DMEM_DATA_WRITE = wd;
    end else begin
      bus4.DMEM_READ = rd; bus4.DMEM_WRITE = wr;
      bus4.DMEM_ADDR = a;  bus4.DMEM_DATA_WRITE = wd;
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    drive(0, RD_NONE, WR_NONE, 32'h0, 32'h0);
    drive(1, RD_NONE, WR_NONE, 32'h0, 32'h0);
  endtask

  // Issue one request in the next cycle, count BUSYWAIT cycles, check DONE.
  // Leaves the request asserted so a following call is back-to-back.
  task automatic do_op(input string tag, input int sel, input logic [3:0] rd,
                       input logic [2:0] wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_d, input logic exp_m);
    int   cnt;
    logic busy;
    exp_q.push_back(exp_d);
    exp_mis_q.push_back(exp_m);
    exp_busy_q.push_back((sel == 1) ? 32'd1 : 32'd4);
    @(posedge clk); #1;
    drive(sel, rd, wr, a, wd);
    cnt  = 0;
    busy = 1'b1;
    while (busy && cnt <= 20) begin
      @(negedge clk);
      busy = (sel == 1) ? bus1.BUSYWAIT : bus4.BUSYWAIT;
      if (busy) begin
        cnt++;
        @(posedge clk);
      end
    end
    check_val({tag, "_busy"}, 32'(cnt), exp_busy_q.pop_front());
    check_val({tag, "_state"}, 32'((sel == 1) ? st1 : st4), 32'd2);
    check_val({tag, "_data"}, (sel == 1) ? bus1.DMEM_DATA_READ : bus4.DMEM_DATA_READ,
              exp_q.pop_front());
    check_val({tag, "_mis"}, 32'((sel == 1) ? bus1.DMEM_MISALIGNED : bus4.DMEM_MISALIGNED),
              32'(exp_mis_q.pop_front()));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    drive(0, RD_NONE, WR_NONE, 32'h0, 32'h0);
    drive(1, RD_NONE, WR_NONE, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    check_val("rst_state4", 32'(st4), 32'd0);
    check_val("rst_busy4", 32'(bus4.BUSYWAIT), 32'd0);
    check_val("rst_data4", bus4.DMEM_DATA_READ, 32'h0);
    check_val("rst_mis4", 32'(bus4.DMEM_MISALIGNED), 32'd0);
    check_val("rst_state1", 32'(st1), 32'd0);
    check_val("rst_data1", bus1.DMEM_DATA_READ, 32'h0);
    rst_n = 1'b1;

    // word, then narrow loads of it
    do_op("sw10",  0, RD_NONE, WR_SW, 32'h10, 32'hDEADBEEF, 32'h00000000, 1'b0);
    do_op("lw10",  0, RD_LW,   WR_NONE, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0); idle();
    do_op("lb13",  0, RD_LB,   WR_NONE, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0); idle();
    do_op("lbu13", 0, RD_LBU,  WR_NONE, 32'h13, 32'h0, 32'h000000DE, 1'b0); idle();
    do_op("lh12",  0, RD_LH,   WR_NONE, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0); idle();
    do_op("lhu10", 0, RD_LHU,  WR_NONE, 32'h10, 32'h0, 32'h0000BEEF, 1'b0); idle();

    // narrow stores touch only their lanes; writes leave read data alone
    do_op("sb11",  0, RD_NONE, WR_SB, 32'h11, 32'hAAAAAA55, 32'h0000BEEF, 1'b0); idle();
    do_op("lw_sb", 0, RD_LW,   WR_NONE, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0); idle();
    do_op("sh12",  0, RD_NONE, WR_SH, 32'h12, 32'hFFFF1234, 32'hDEAD55EF, 1'b0); idle();
    do_op("lw_sh", 0, RD_LW,   WR_NONE, 32'h10, 32'h0, 32'h123455EF, 1'b0); idle();

    // misaligned word, single-cycle pulse, address wrap
    do_op("lw12_mis", 0, RD_LW, WR_NONE, 32'h12, 32'h0, 32'h123455EF, 1'b1); idle();
    @(negedge clk);
    check_val("mis_clear", 32'(bus4.DMEM_MISALIGNED), 32'd0);
    do_op("lw1010", 0, RD_LW, WR_NONE, 32'h1010, 32'h0, 32'h123455EF, 1'b0); idle();

    // invalid funct3 returns 0 at full latency; read+write together -> write
    do_op("lbad",  0, RD_BAD, WR_NONE, 32'h10, 32'h0, 32'h00000000, 1'b0); idle();
    do_op("lw10b", 0, RD_LW,  WR_NONE, 32'h10, 32'h0, 32'h123455EF, 1'b0); idle();
    do_op("rw20",  0, RD_LW,  WR_SW,   32'h20, 32'h0BADF00D, 32'h123455EF, 1'b0); idle();
    do_op("lw20",  0, RD_LW,  WR_NONE, 32'h20, 32'h0, 32'h0BADF00D, 1'b0); idle();

    // random words, back-to-back stores then back-to-back loads
    for (int i = 0; i < 8; i++) begin
      rnd_data[i] = $urandom();
      do_op("rnd_sw", 0, RD_NONE, WR_SW, 32'h100 + 32'(4 * i), rnd_data[i], 32'h0BADF00D, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      do_op("rnd_lw", 0, RD_LW, WR_NONE, 32'h100 + 32'(4 * i), 32'h0, rnd_data[i], 1'b0);
    end
    idle();

    // LATENCY=1 back-to-back store then load
    do_op("l1_sw", 1, RD_NONE, WR_SW, 32'h40, 32'h600DCAFE, 32'h00000000, 1'b0);
    do_op("l1_lw", 1, RD_LW,   WR_NONE, 32'h40, 32'h0, 32'h600DCAFE, 1'b0); idle();

    // reset in cycle 2 of a store: store must not land
    @(posedge clk); #1;
    drive(0, RD_NONE, WR_SW, 32'h10, 32'hCAFEF00D);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_val("rst_mid_pre", 32'(st4), 32'd1);
    rst_n = 1'b0;
    drive(0, RD_NONE, WR_NONE, 32'h0, 32'h0);
    #1;
    check_val("rst_mid_busy", 32'(bus4.BUSYWAIT), 32'd0);
    check_val("rst_mid_state", 32'(st4), 32'd0);
    check_val("rst_mid_data", bus4.DMEM_DATA_READ, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("lw_after_rst", 0, RD_LW, WR_NONE, 32'h10, 32'h0, 32'h123455EF, 1'b0); idle();

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
